// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out stage feeding the sequence detector.
// Holds the state encoding and the bit-counter width helper.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter must index 0..width-1; never let it collapse to zero bits.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake plus serial output bundle of the serializer.
// master = producer/consumer side, slave = serializer side.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             last;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, last, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word over valid/ready and emits
// one bit per clock on sout, reloading on the last bit so words stream gap-free.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no word held; din_ready=1, sout=IDLE_LEVEL
// ST_SHIFT | word in flight; cnt = index of the bit on sout (0..WIDTH-1)
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_serializer_if.slave bus
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int               OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_last;
    logic             ready;
    logic             accept;

    // Ready depends on registered state only, so it never loops back through din_valid.
    assign at_last = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign ready   = (state_q == ST_IDLE) || at_last;
    assign accept  = bus.din_valid && ready;

    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    sreg_d  = bus.din;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (!at_last) begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (accept) begin
                    sreg_d = bus.din;
                    cnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    sreg_d  = sreg_shifted;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // sout is the register end bit, forced to the idle level outside a word.
    assign bus.sout       = (state_q == ST_SHIFT) ? sreg_q[OUT_IDX] : IDLE_LEVEL;
    assign bus.sout_valid = (state_q == ST_SHIFT);
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.last       = at_last;
    assign bus.din_ready  = ready;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus randomized traffic
// compared against a queue-of-pending-bits reference model.
module tb_piso_serializer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Reference model: bits still to appear on sout, head = bit currently on sout.
    bit mq[$];
    bit lq[$];

    piso_serializer_if #(.WIDTH(8)) bm();
    piso_serializer_if #(.WIDTH(8)) bl();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bm.slave)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bl.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock edge on the MSB-first unit; model accepts when at most one bit is pending.
    task automatic cyc_msb(input logic v, input logic [7:0] w);
        bit acc;
        bm.din_valid = v;
        bm.din       = w;
        acc = v && (mq.size() <= 1);
        @(posedge clk);
        if (mq.size() > 0) mq.delete(0);
        if (acc) for (int i = 7; i >= 0; i--) mq.push_back(w[i]);
        @(negedge clk);
    endtask

    task automatic cyc_lsb(input logic v, input logic [7:0] w);
        bit acc;
        bl.din_valid = v;
        bl.din       = w;
        acc = v && (lq.size() <= 1);
        @(posedge clk);
        if (lq.size() > 0) lq.delete(0);
        if (acc) for (int i = 0; i < 8; i++) lq.push_back(w[i]);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bm.din_valid = 1'b0; bm.din = '0;
        bl.din_valid = 1'b0; bl.din = '0;
        #3;
        total++; if (bm.sout !== 1'b0)       begin bad++; $display("FAIL rst_msb_sout: got %b want 0", bm.sout); end
        total++; if (bm.sout_valid !== 1'b0) begin bad++; $display("FAIL rst_msb_valid: got %b want 0", bm.sout_valid); end
        total++; if (bm.last !== 1'b0)       begin bad++; $display("FAIL rst_msb_last: got %b want 0", bm.last); end
        total++; if (bm.busy !== 1'b0)       begin bad++; $display("FAIL rst_msb_busy: got %b want 0", bm.busy); end
        total++; if (bm.din_ready !== 1'b1)  begin bad++; $display("FAIL rst_msb_ready: got %b want 1", bm.din_ready); end
        total++; if (bl.sout !== 1'b1)       begin bad++; $display("FAIL rst_lsb_sout_idle: got %b want 1", bl.sout); end
        total++; if (bl.sout_valid !== 1'b0) begin bad++; $display("FAIL rst_lsb_valid: got %b want 0", bl.sout_valid); end
        total++; if (bl.din_ready !== 1'b1)  begin bad++; $display("FAIL rst_lsb_ready: got %b want 1", bl.din_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mq.delete(); lq.delete();
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'hA6;
        total++; if (bm.din_ready !== 1'b1) begin bad++; $display("FAIL single_ready_idle: got %b want 1", bm.din_ready); end
        cyc_msb(1'b1, w);
        for (int i = 0; i < 8; i++) begin
            total++; if (bm.sout !== w[7-i])     begin bad++; $display("FAIL single_sout[%0d]: got %b want %b", i, bm.sout, w[7-i]); end
            total++; if (bm.sout_valid !== 1'b1) begin bad++; $display("FAIL single_valid[%0d]: got %b want 1", i, bm.sout_valid); end
            total++; if (bm.busy !== 1'b1)       begin bad++; $display("FAIL single_busy[%0d]: got %b want 1", i, bm.busy); end
            total++; if (bm.last !== (i == 7))   begin bad++; $display("FAIL single_last[%0d]: got %b want %b", i, bm.last, (i == 7)); end
            total++; if (bm.din_ready !== (i == 7)) begin bad++; $display("FAIL single_ready[%0d]: got %b want %b", i, bm.din_ready, (i == 7)); end
            cyc_msb(1'b0, 8'h00);
        end
        total++; if (bm.sout_valid !== 1'b0) begin bad++; $display("FAIL single_end_valid: got %b want 0", bm.sout_valid); end
        total++; if (bm.din_ready !== 1'b1)  begin bad++; $display("FAIL single_end_ready: got %b want 1", bm.din_ready); end
        total++; if (bm.sout !== 1'b0)       begin bad++; $display("FAIL single_end_sout: got %b want 0", bm.sout); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = 16'b1010_0101_0011_1100;
        cyc_msb(1'b1, 8'hA5);
        for (int i = 0; i < 16; i++) begin
            total++; if (bm.sout !== stream[15-i]) begin bad++; $display("FAIL b2b_sout[%0d]: got %b want %b", i, bm.sout, stream[15-i]); end
            total++; if (bm.sout_valid !== 1'b1)   begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bm.sout_valid); end
            total++; if (bm.last !== (i == 7 || i == 15)) begin bad++; $display("FAIL b2b_last[%0d]: got %b want %b", i, bm.last, (i == 7 || i == 15)); end
            total++; if (bm.din_ready !== (i == 7 || i == 15)) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, bm.din_ready, (i == 7 || i == 15)); end
            cyc_msb(i <= 7, 8'h3C);
        end
        total++; if (bm.busy !== 1'b0) begin bad++; $display("FAIL b2b_end_busy: got %b want 0", bm.busy); end
    endtask

    task automatic test_busy_ignore();
        cyc_msb(1'b1, 8'hFF);
        for (int i = 0; i < 16; i++) begin
            total++; if (bm.sout !== (i < 8)) begin bad++; $display("FAIL ignore_sout[%0d]: got %b want %b", i, bm.sout, (i < 8)); end
            total++; if (bm.sout_valid !== 1'b1) begin bad++; $display("FAIL ignore_valid[%0d]: got %b want 1", i, bm.sout_valid); end
            cyc_msb(i >= 3 && i <= 7, 8'h00);
        end
        total++; if (bm.sout_valid !== 1'b0) begin bad++; $display("FAIL ignore_end_valid: got %b want 0", bm.sout_valid); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'h01;
        cyc_lsb(1'b1, w);
        for (int i = 0; i < 8; i++) begin
            total++; if (bl.sout !== w[i])      begin bad++; $display("FAIL lsb_sout[%0d]: got %b want %b", i, bl.sout, w[i]); end
            total++; if (bl.last !== (i == 7))  begin bad++; $display("FAIL lsb_last[%0d]: got %b want %b", i, bl.last, (i == 7)); end
            cyc_lsb(1'b0, 8'h00);
        end
        total++; if (bl.sout !== 1'b1)       begin bad++; $display("FAIL lsb_idle_level: got %b want 1", bl.sout); end
        total++; if (bl.sout_valid !== 1'b0) begin bad++; $display("FAIL lsb_idle_valid: got %b want 0", bl.sout_valid); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        w = 8'b0101_1000;
        cyc_msb(1'b1, 8'($urandom));
        for (int i = 0; i < 4; i++) cyc_msb(1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bm.sout_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bm.sout_valid); end
        total++; if (bm.busy !== 1'b0)       begin bad++; $display("FAIL midrst_busy: got %b want 0", bm.busy); end
        total++; if (bm.last !== 1'b0)       begin bad++; $display("FAIL midrst_last: got %b want 0", bm.last); end
        total++; if (bm.sout !== 1'b0)       begin bad++; $display("FAIL midrst_sout: got %b want 0", bm.sout); end
        mq.delete(); lq.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if (bm.din_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after: got %b want 1", bm.din_ready); end
        cyc_msb(1'b1, w);
        for (int i = 0; i < 8; i++) begin
            total++; if (bm.sout !== w[7-i]) begin bad++; $display("FAIL midrst_word_sout[%0d]: got %b want %b", i, bm.sout, w[7-i]); end
            cyc_msb(1'b0, 8'h00);
        end
    endtask

    task automatic test_random_msb();
        bit e_v, e_s;
        for (int c = 0; c < 400; c++) begin
            e_v = (mq.size() > 0);
            e_s = e_v ? mq[0] : 1'b0;
            total++;
            if (bm.sout !== e_s || bm.sout_valid !== e_v || bm.busy !== e_v ||
                bm.last !== (mq.size() == 1) || bm.din_ready !== (mq.size() <= 1)) begin
                bad++;
                $display("FAIL rand_msb[%0d]: got sout=%b v=%b busy=%b last=%b rdy=%b want sout=%b v=%b last=%b rdy=%b",
                         c, bm.sout, bm.sout_valid, bm.busy, bm.last, bm.din_ready,
                         e_s, e_v, (mq.size() == 1), (mq.size() <= 1));
            end
            cyc_msb($urandom_range(0, 9) < 6, 8'($urandom));
        end
        bm.din_valid = 1'b0;
    endtask

    task automatic test_random_lsb();
        bit e_v, e_s;
        for (int c = 0; c < 300; c++) begin
            e_v = (lq.size() > 0);
            e_s = e_v ? lq[0] : 1'b1;
            total++;
            if (bl.sout !== e_s || bl.sout_valid !== e_v || bl.busy !== e_v ||
                bl.last !== (lq.size() == 1) || bl.din_ready !== (lq.size() <= 1)) begin
                bad++;
                $display("FAIL rand_lsb[%0d]: got sout=%b v=%b busy=%b last=%b rdy=%b want sout=%b v=%b last=%b rdy=%b",
                         c, bl.sout, bl.sout_valid, bl.busy, bl.last, bl.din_ready,
                         e_s, e_v, (lq.size() == 1), (lq.size() <= 1));
            end
            cyc_lsb($urandom_range(0, 9) < 7, 8'($urandom));
        end
        bl.din_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_ignore();
        test_lsb_first();
        test_reset_mid_word();
        test_random_msb();
        test_random_lsb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
